// File: rtl/nibble_serial_adder_if.sv
// Operand/result bundle for nibble_serial_adder; slave = adder side, master = producer/consumer side.
// Optional sub port present only when NIBBLE_SERIAL_ADDER_SUB_EN is defined.
interface nibble_serial_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    logic             sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;

    modport slave (
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
        input  sub,
`endif
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, busy
    );

    modport master (
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
        output sub,
`endif
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, busy
    );
endinterface

// File: rtl/nibble_serial_adder.sv
// Serial WIDTH-bit adder through one 4-bit slice, LSB nibble first; optional subtract via NIBBLE_SERIAL_ADDER_SUB_EN.
// Result valid WIDTH/4 edges after accept; holds result until out_ready, in_ready only in IDLE.
module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    nibble_serial_adder_if.slave bus
);
    localparam int NIB  = WIDTH / 4;
    localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;

    generate
        if (WIDTH < 4 || (WIDTH % 4) != 0) begin : g_bad_width
            $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic [WIDTH-1:0]  r_sum;
    logic              r_carry;
    logic              r_cout;
    logic [IDXW-1:0]   r_idx;

    logic              w_in_ready;
    logic              w_out_valid;
    logic              w_busy;
    logic              w_accept;
    logic              w_last;
    logic              w_sub;
    logic [IDXW+1:0]   w_base;
    logic [3:0]        w_a_nib;
    logic [3:0]        w_b_nib;
    logic [4:0]        w_slice;

`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    assign w_sub = bus.sub;
`else
    assign w_sub = 1'b0;
`endif

    assign w_accept = w_in_ready & bus.in_valid;
    assign w_last   = (r_idx == IDXW'(NIB - 1));
    assign w_base   = {r_idx, 2'b00};
    assign w_a_nib  = r_a[w_base +: 4];
    assign w_b_nib  = r_b[w_base +: 4];
    assign w_slice  = {1'b0, w_a_nib} + {1'b0, w_b_nib} + {4'b0000, r_carry};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        w_busy      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                w_busy = 1'b1;
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_busy      = 1'b1;
                w_out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Subtraction is A + ~B + 1: B is inverted at capture and the carry seeded with 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_idx   <= '0;
        end else if (w_accept) begin
            r_a     <= bus.a;
            r_b     <= w_sub ? ~bus.b : bus.b;
            r_carry <= w_sub ? 1'b1 : bus.cin;
            r_idx   <= '0;
        end else if (r_state == S_RUN) begin
            r_sum[w_base +: 4] <= w_slice[3:0];
            r_carry            <= w_slice[4];
            r_idx              <= r_idx + 1'b1;
            if (w_last) begin
                r_cout <= w_slice[4];
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.busy      = w_busy;
    assign bus.sum       = r_sum;
    assign bus.cout      = r_cout;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Randomized and directed checks of nibble_serial_adder against an arithmetic reference model.
module tb_nibble_serial_adder;
    localparam int W   = 16;
    localparam int NIB = W / 4;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    nibble_serial_adder_if #(.WIDTH(W)) bus ();

    nibble_serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic cin, input logic sub);
        logic [W-1:0] d;
        if (sub) begin
            d = a - b;
            return {(a >= b), d};
        end
        return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    endfunction

    task automatic drive_sub(input logic s);
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
        bus.sub = s;
`else
        if (s) $display("note: sub requested without subtract support");
`endif
    endtask

    // Presents one bundle and returns just after the accepting edge.
    task automatic accept_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input logic s);
        @(negedge clk);
        bus.a = a; bus.b = b; bus.cin = cin; drive_sub(s);
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    // Counts edges after the accept edge until out_valid; -1 on timeout.
    task automatic wait_done(output int lat);
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (bus.out_valid) return;
        end
        lat = -1;
    endtask

    task automatic release_result();
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
    endtask

    task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic s);
        logic [W:0] exp;
        int lat;
        exp = model(a, b, cin, s);
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s idle in_ready got %b want 1", name, bus.in_ready);
        end
        accept_op(a, b, cin, s);
        wait_done(lat);
        checks++;
        if (lat !== NIB) begin
            failures++;
            $display("FAIL %s latency got %0d want %0d", name, lat, NIB);
        end
        checks++;
        if ({bus.cout, bus.sum} !== exp) begin
            failures++;
            $display("FAIL %s result got cout=%b sum=%h want cout=%b sum=%h",
                     name, bus.cout, bus.sum, exp[W], exp[W-1:0]);
        end
        release_result();
    endtask

    task automatic test_reset();
        checks++;
        if ({bus.in_ready, bus.out_valid, bus.busy, bus.cout} !== 4'b1000 || bus.sum !== '0) begin
            failures++;
            $display("FAIL reset got in_ready=%b out_valid=%b busy=%b cout=%b sum=%h want 1 0 0 0 0000",
                     bus.in_ready, bus.out_valid, bus.busy, bus.cout, bus.sum);
        end
    endtask

    task automatic test_directed();
        run_op("carry_nibble", 16'h00FF, 16'h0001, 1'b0, 1'b0);
        run_op("carry_all", 16'hFFFF, 16'h0001, 1'b0, 1'b0);
        run_op("cin_only", 16'h0000, 16'h0000, 1'b1, 1'b0);
        run_op("max_cin", 16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++) begin
            run_op("random", W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'b0);
        end
    endtask

    task automatic test_stall();
        int lat;
        int bad;
        accept_op(16'h1234, 16'h1111, 1'b0, 1'b0);
        bus.a = 16'h0003; bus.b = 16'h0004; bus.cin = 1'b0; bus.in_valid = 1'b1;
        checks++;
        if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL stall_run busy=%b in_ready=%b want 1 0", bus.busy, bus.in_ready);
        end
        wait_done(lat);
        checks++;
        if (lat !== NIB) begin
            failures++;
            $display("FAIL stall_latency got %0d want %0d", lat, NIB);
        end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.out_valid !== 1'b1 || bus.sum !== 16'h2345 || bus.cout !== 1'b0 || bus.in_ready !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL stall_hold got %0d unstable cycles want 0 (last sum=%h out_valid=%b)",
                     bad, bus.sum, bus.out_valid);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL stall_idle out_valid=%b in_ready=%b want 0 1", bus.out_valid, bus.in_ready);
        end
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        wait_done(lat);
        checks++;
        if (lat !== NIB || bus.sum !== 16'h0007 || bus.cout !== 1'b0) begin
            failures++;
            $display("FAIL stall_pending got lat=%0d sum=%h cout=%b want %0d 0007 0", lat, bus.sum, bus.cout, NIB);
        end
        release_result();
    endtask

    task automatic test_reset_mid();
        int seen;
        accept_op(16'hAAAA, 16'h5555, 1'b1, 1'b0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.in_ready, bus.out_valid, bus.busy, bus.cout} !== 4'b1000 || bus.sum !== '0) begin
            failures++;
            $display("FAIL mid_reset got in_ready=%b out_valid=%b busy=%b cout=%b sum=%h want 1 0 0 0 0000",
                     bus.in_ready, bus.out_valid, bus.busy, bus.cout, bus.sum);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL post_reset_quiet got %0d active cycles want 0", seen);
        end
        run_op("after_reset", 16'h0003, 16'h0004, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] opa [3];
        logic [W-1:0] opb [3];
        logic [W:0]   exp_q [$];
        logic [W:0]   exp;
        int n_acc, n_res, last_acc;
        logic prev_v;
        for (int i = 0; i < 3; i++) begin
            opa[i] = W'($urandom);
            opb[i] = W'($urandom);
        end
        n_acc = 0; n_res = 0; last_acc = 0; prev_v = 1'b0;
        @(negedge clk);
        bus.a = opa[0]; bus.b = opb[0]; bus.cin = 1'b0;
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        for (int cyc = 0; cyc < 80 && n_res < 3; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (bus.out_valid) begin
                exp = exp_q.pop_front();
                checks++;
                if ({bus.cout, bus.sum} !== exp || prev_v) begin
                    failures++;
                    $display("FAIL b2b_result%0d got cout=%b sum=%h prev_valid=%b want cout=%b sum=%h prev_valid=0",
                             n_res, bus.cout, bus.sum, prev_v, exp[W], exp[W-1:0]);
                end
                n_res++;
            end
            prev_v = bus.out_valid;
            if (bus.in_ready && n_acc < 3) begin
                if (n_acc > 0) begin
                    checks++;
                    if (cyc - last_acc != NIB + 2) begin
                        failures++;
                        $display("FAIL b2b_spacing got %0d want %0d", cyc - last_acc, NIB + 2);
                    end
                end
                exp_q.push_back(model(bus.a, bus.b, bus.cin, 1'b0));
                last_acc = cyc;
                n_acc++;
                @(posedge clk);
                #1;
                if (n_acc < 3) begin
                    bus.a = opa[n_acc]; bus.b = opb[n_acc];
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        checks++;
        if (n_res != 3) begin
            failures++;
            $display("FAIL b2b_count got %0d results want 3", n_res);
        end
    endtask

`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    task automatic test_sub();
        run_op("sub_borrow", 16'h0005, 16'h0007, 1'b0, 1'b1);
        run_op("sub_noborrow", 16'h0009, 16'h0002, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) begin
            run_op("sub_random", W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'b1);
        end
        drive_sub(1'b0);
    endtask
`endif

    initial begin
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.cin = 1'b0;
        bus.out_ready = 1'b0;
        drive_sub(1'b0);
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        test_directed();
        test_random();
        test_stall();
        test_reset_mid();
        test_back_to_back();
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
        test_sub();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
